pipe_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage CPU pipeline (F,D,E,M,W). Drives the

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage F/D/E/M/W pipeline: load-use bubbles,
// taken-branch redirects and multi-cycle memory waits with timeout abort.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadE,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic             branch_takenE,
  input  logic             dmem_reqM,
  input  logic             dmem_ackM,
  input  logic             imem_reqF,
  input  logic             imem_ackF,
  output logic             enbF,
  output logic             enbD,
  output logic             enbE,
  output logic             enbM,
  output logic             enbW,
  output logic             flashD,
  output logic             flashE,
  output logic             flashM,
  output logic             flashW,
  output logic             pc_redirect,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT} stateT;

  stateT          st;
  stateT          nextSt;
  logic [WCW-1:0] waitCnt;
  logic           iAckPend;
  logic           pendNext;
  logic           waitAck;
  logic           timeoutHit;
  logic           dWait;
  logic           iWait;
  logic           loadUse;
  logic           hazHold;

  always_comb begin
    enbF        = 1'b0;
    enbD        = 1'b0;
    enbE        = 1'b0;
    enbM        = 1'b0;
    enbW        = 1'b0;
    flashD      = 1'b0;
    flashE      = 1'b0;
    flashM      = 1'b0;
    flashW      = 1'b0;
    pc_redirect = 1'b0;
    hazHold     = 1'b0;
    nextSt      = RUN;
    pendNext    = iAckPend;

    loadUse = loadE && (rdE != 5'd0) &&
              ((use_rs1D && (rs1D == rdE)) || (use_rs2D && (rs2D == rdE)));
    waitAck    = (st == DWAIT) ? dmem_ackM : imem_ackF;
    timeoutHit = (st != RUN) && !waitAck && (waitCnt == WAIT_LAST);
    dWait      = ((st == RUN) && dmem_reqM && !dmem_ackM) || ((st == DWAIT) && !dmem_ackM);
    // An acked DWAIT cycle behaves like RUN, so only IWAIT ignores the pending-ack flag.
    iWait      = (st == IWAIT) ? !imem_ackF : (imem_reqF && !imem_ackF && !iAckPend);

    if (!rst_n) begin
      flashD = 1'b1;
      flashE = 1'b1;
      flashM = 1'b1;
      flashW = 1'b1;
    end else if (timeoutHit) begin
      flashD = 1'b1;
      flashE = 1'b1;
      flashM = 1'b1;
      flashW = 1'b1;
    end else if (dWait) begin
      enbF    = 1'b1;
      enbD    = 1'b1;
      enbE    = 1'b1;
      enbM    = 1'b1;
      flashW  = 1'b1;
      hazHold = 1'b1;
      nextSt  = DWAIT;
    end else if (branch_takenE) begin
      pc_redirect = 1'b1;
      flashD      = 1'b1;
      flashE      = 1'b1;
    end else if (loadUse) begin
      enbF    = 1'b1;
      enbD    = 1'b1;
      flashE  = 1'b1;
      hazHold = 1'b1;
      nextSt  = ((st == IWAIT) && !imem_ackF) ? IWAIT : RUN;
    end else if (iWait) begin
      enbF   = 1'b1;
      flashD = 1'b1;
      nextSt = IWAIT;
    end

    // A fetch ack that lands while F is frozen is banked until F next advances.
    if (hazHold && imem_ackF) begin
      pendNext = 1'b1;
    end else if (!enbF) begin
      pendNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= RUN;
      waitCnt      <= '0;
      iAckPend     <= 1'b0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      st          <= nextSt;
      iAckPend    <= pendNext;
      timeout_err <= timeoutHit;
      if (nextSt == RUN) begin
        waitCnt <= '0;
      end else if (nextSt == st) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= WCW'(1);
      end
      if (enbF && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal expectations
// plus a per-cycle behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT   = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             loadE;
  logic [4:0]       rdE;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             use_rs1D;
  logic             use_rs2D;
  logic             branch_takenE;
  logic             dmem_reqM;
  logic             dmem_ackM;
  logic             imem_reqF;
  logic             imem_ackF;
  logic             enbF, enbD, enbE, enbM, enbW;
  logic             flashD, flashE, flashM, flashW;
  logic             pc_redirect;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  // Model state: kind of wait in progress (0 none, 1 data, 2 fetch), cycles spent
  // in it, whether a fetch ack is banked, stall count and the abort pulse.
  int mWaitKind = 0, mWaited = 0, mStalls = 0;
  bit mBanked = 1'b0, mAbort = 1'b0;
  int nWaitKind = 0, nWaited = 0, nStalls = 0;
  bit nBanked = 1'b0, nAbort = 1'b0;

  logic [10:0] expV;
  logic [10:0] actV;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .loadE(loadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
    .use_rs1D(use_rs1D), .use_rs2D(use_rs2D), .branch_takenE(branch_takenE),
    .dmem_reqM(dmem_reqM), .dmem_ackM(dmem_ackM), .imem_reqF(imem_reqF),
    .imem_ackF(imem_ackF), .enbF(enbF), .enbD(enbD), .enbE(enbE), .enbM(enbM),
    .enbW(enbW), .flashD(flashD), .flashE(flashE), .flashM(flashM), .flashW(flashW),
    .pc_redirect(pc_redirect), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    loadE = 0; rdE = 0; rs1D = 0; rs2D = 0; use_rs1D = 0; use_rs2D = 0;
    branch_takenE = 0; dmem_reqM = 0; dmem_ackM = 0; imem_reqF = 0; imem_ackF = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
  endtask

  // Expected outputs this cycle, and the model's state after the coming edge.
  task automatic modelStep(output logic [10:0] e);
    bit ackNow, expired, dataBusy, fetchBusy, bubble;
    int act, holdDepth;
    bit fD, fE, fM, fW, redir;
    if (!rst_n) begin
      e = 11'b00000_1111_0_0;
      nWaitKind = 0; nWaited = 0; nStalls = 0; nBanked = 0; nAbort = 0;
      return;
    end
    ackNow    = (mWaitKind == 1) ? dmem_ackM : imem_ackF;
    expired   = (mWaitKind != 0) && (mWaited == TIMEOUT - 1) && !ackNow;
    dataBusy  = (mWaitKind == 1 && !dmem_ackM) || (mWaitKind == 0 && dmem_reqM && !dmem_ackM);
    bubble    = loadE && rdE != 0 && ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
    fetchBusy = (mWaitKind == 2) ? !imem_ackF : (imem_reqF && !imem_ackF && !mBanked);
    if (expired) act = 1;
    else if (dataBusy) act = 2;
    else if (branch_takenE) act = 3;
    else if (bubble) act = 4;
    else if (fetchBusy) act = 5;
    else act = 0;
    holdDepth = 0; fD = 0; fE = 0; fM = 0; fW = 0; redir = 0; nWaitKind = 0;
    case (act)
      1: begin fD = 1; fE = 1; fM = 1; fW = 1; end
      2: begin holdDepth = 4; fW = 1; nWaitKind = 1; end
      3: begin redir = 1; fD = 1; fE = 1; end
      4: begin holdDepth = 2; fE = 1; nWaitKind = (mWaitKind == 2 && !imem_ackF) ? 2 : 0; end
      5: begin holdDepth = 1; fD = 1; nWaitKind = 2; end
      default: ;
    endcase
    e = {holdDepth >= 1, holdDepth >= 2, holdDepth >= 3, holdDepth >= 4, 1'b0,
         fD, fE, fM, fW, redir, mAbort};
    nWaited = (nWaitKind == 0) ? 0 : ((nWaitKind == mWaitKind) ? mWaited + 1 : 1);
    nAbort  = (act == 1);
    nStalls = (holdDepth > 0 && mStalls < STALL_MAX) ? mStalls + 1 : mStalls;
    if ((act == 2 || act == 4) && imem_ackF) nBanked = 1;
    else if (holdDepth == 0) nBanked = 0;
    else nBanked = mBanked;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mWaitKind = 0; mWaited = 0; mStalls = 0; mBanked = 0; mAbort = 0;
    end else begin
      mWaitKind = nWaitKind; mWaited = nWaited; mStalls = nStalls;
      mBanked = nBanked; mAbort = nAbort;
    end
  end

  always @(negedge clk) begin
    modelStep(expV);
    actV = {enbF, enbD, enbE, enbM, enbW, flashD, flashE, flashM, flashW, pc_redirect, timeout_err};
    checkOutput("model_outputs", 32'(actV), 32'(expV));
    checkOutput("model_stall_cycles", 32'(stall_cycles), 32'(mStalls));
  end

  initial begin
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_flush", 32'({flashD, flashE, flashM, flashW}), 32'hF);
    checkOutput("reset_enb", 32'({enbF, enbD, enbE, enbM, enbW, pc_redirect}), 32'h0);
    checkOutput("reset_stall", 32'(stall_cycles), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Load-use on rs1: one bubble.
    loadE = 1; rdE = 5; rs1D = 5; use_rs1D = 1;
    @(negedge clk);
    checkOutput("loaduse_hold", 32'({enbF, enbD, enbE, flashE}), 32'b1101);
    checkOutput("loaduse_stall_before", 32'(stall_cycles), 32'h0);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("loaduse_single_bubble", 32'({enbF, enbD, flashE}), 32'h0);
    checkOutput("loaduse_stall_after", 32'(stall_cycles), 32'h1);
    applyStimulus();

    // Branch beats same-cycle load-use.
    loadE = 1; rdE = 5; rs1D = 5; use_rs1D = 1; branch_takenE = 1;
    @(negedge clk);
    checkOutput("branch_wins", 32'({pc_redirect, flashD, flashE, enbF}), 32'b1110);
    applyStimulus();
    clearInputs();

    // rd of x0 never stalls; unused operand never stalls; rs2 match does.
    loadE = 1; rdE = 0; rs1D = 0; use_rs1D = 1;
    @(negedge clk);
    checkOutput("loaduse_x0", 32'(enbF), 32'h0);
    applyStimulus();
    rdE = 9; rs1D = 9; use_rs1D = 0;
    @(negedge clk);
    checkOutput("loaduse_unused_src", 32'(enbF), 32'h0);
    applyStimulus();
    rs2D = 9; use_rs2D = 1;
    @(negedge clk);
    checkOutput("loaduse_rs2", 32'({enbF, enbD, flashE}), 32'b111);
    applyStimulus();

    // Data wait released by ack on the fifth cycle.
    doReset();
    dmem_reqM = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("dwait_hold", 32'({enbF, enbD, enbE, enbM, flashW}), 32'b11111);
      applyStimulus();
    end
    dmem_ackM = 1;
    @(negedge clk);
    checkOutput("dwait_release", 32'({enbF, enbD, enbE, enbM, flashW}), 32'h0);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("dwait_stall_count", 32'(stall_cycles), 32'h4);
    applyStimulus();

    // Data wait timeout: abort on the eighth cycle, one-cycle error pulse.
    doReset();
    dmem_reqM = 1;
    repeat (7) applyStimulus();
    @(negedge clk);
    checkOutput("dtimeout_flush", 32'({flashD, flashE, flashM, flashW, enbF, enbM}), 32'b111100);
    checkOutput("dtimeout_err_late", 32'(timeout_err), 32'h0);
    applyStimulus();
    dmem_reqM = 0;
    @(negedge clk);
    checkOutput("dtimeout_err_pulse", 32'(timeout_err), 32'h1);
    applyStimulus();
    @(negedge clk);
    checkOutput("dtimeout_err_clear", 32'(timeout_err), 32'h0);
    checkOutput("dtimeout_stalls", 32'(stall_cycles), 32'h7);
    applyStimulus();

    // Fetch ack banked during a data wait lets F advance on release.
    doReset();
    dmem_reqM = 1; imem_reqF = 1;
    applyStimulus();
    imem_ackF = 1;
    @(negedge clk);
    checkOutput("pend_held", 32'(enbF), 32'h1);
    applyStimulus();
    imem_ackF = 0;
    applyStimulus();
    dmem_ackM = 1;
    @(negedge clk);
    checkOutput("pend_release", 32'({enbF, flashD}), 32'b00);
    applyStimulus();
    dmem_reqM = 0; dmem_ackM = 0;
    @(negedge clk);
    checkOutput("pend_consumed", 32'({enbF, flashD}), 32'b11);
    applyStimulus();
    imem_ackF = 1;
    @(negedge clk);
    checkOutput("iwait_ack", 32'({enbF, flashD}), 32'b00);
    applyStimulus();
    clearInputs();

    // Reset in the middle of a data wait.
    doReset();
    dmem_reqM = 1;
    repeat (3) applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("midwait_reset_flush", 32'({flashD, flashE, flashM, flashW, enbF}), 32'b11110);
    checkOutput("midwait_reset_stall", 32'(stall_cycles), 32'h0);
    applyStimulus();
    rst_n = 1'b1;
    repeat (7) applyStimulus();
    @(negedge clk);
    checkOutput("midwait_fresh_timeout", 32'({flashD, flashW, enbF}), 32'b110);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("midwait_err_pulse", 32'(timeout_err), 32'h1);
    applyStimulus();

    // Fetch wait timeout.
    doReset();
    imem_reqF = 1;
    repeat (7) applyStimulus();
    @(negedge clk);
    checkOutput("itimeout_flush", 32'({flashD, flashE, flashM, flashW, enbF}), 32'b11110);
    applyStimulus();
    imem_reqF = 0;
    @(negedge clk);
    checkOutput("itimeout_err", 32'(timeout_err), 32'h1);
    applyStimulus();

    // Branch during fetch wait, then load-use catching a fetch ack.
    imem_reqF = 1;
    applyStimulus();
    branch_takenE = 1;
    @(negedge clk);
    checkOutput("iwait_branch", 32'({pc_redirect, enbF, flashD}), 32'b101);
    applyStimulus();
    branch_takenE = 0;
    applyStimulus();
    loadE = 1; rdE = 3; rs1D = 3; use_rs1D = 1; imem_ackF = 1;
    applyStimulus();
    clearInputs();
    imem_reqF = 1;
    @(negedge clk);
    checkOutput("loaduse_banked_fetch", 32'({enbF, flashD}), 32'b00);
    applyStimulus();
    clearInputs();

    // Stall counter saturates.
    doReset();
    loadE = 1; rdE = 4; rs2D = 4; use_rs2D = 1;
    repeat (20) applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("stall_saturate", 32'(stall_cycles), 32'(STALL_MAX));
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
